// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the four-source bus arbiter.
// Holds the FSM state encoding, control-module ID and header field positions.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] CTRL_ID = 2'b11;
    localparam int         SRC_LSB = 2;
    localparam int         DST_LSB = 4;

    function automatic logic [3:0] id_onehot(input logic [1:0] id);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick3.sv
// Round-robin choice among sources 0..2.
// Search starts at the source just after the previous non-control winner.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last_id,
    output logic [2:0] pick
);

    // Rotate the search order so the previous winner is tried last.
    always_comb begin
        pick = 3'b000;
        case (last_id)
            2'd0: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd1: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-source bus arbiter with header capture and beat counting.
// Optional bus-idle watchdog is built when ARB_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    output logic [3:0] grant,
    output logic       busy,
    output logic       hdr_valid,
    output logic [1:0] hdr_src,
    output logic [1:0] hdr_dst,
    output logic [7:0] beat_cnt,
    output logic       hdr_err,
    output logic       timeout
);

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_nc_q, last_nc_d;
    logic       hdr_valid_q, hdr_valid_d;
    logic [1:0] hdr_src_q, hdr_src_d;
    logic [1:0] hdr_dst_q, hdr_dst_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       hdr_err_q, hdr_err_d;
    logic       timeout_q, timeout_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;

    logic [2:0] rr_pick;
    logic [1:0] win_id;
    logic       rel;
    logic       wd_fire;

    // Header bits outside the src/dst fields carry no meaning here.
    logic unused_data;
    assign unused_data = ^{bus_data[7:6], bus_data[1:0]};

    rr_pick3 u_rr (
        .req     (req[2:0]),
        .last_id (last_nc_q),
        .pick    (rr_pick)
    );

    // Control module pre-empts the round-robin choice.
    always_comb begin
        win_id = 2'd0;
        if (req[3])          win_id = CTRL_ID;
        else if (rr_pick[1]) win_id = 2'd1;
        else if (rr_pick[2]) win_id = 2'd2;
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] idle_cnt_q, idle_cnt_d;

    // Count consecutive beat-less cycles while a grant is held.
    always_comb begin
        idle_cnt_d = 8'd0;
        wd_fire    = 1'b0;
        if ((state_q == HDR || state_q == XFER) && !bus_valid) begin
            if (idle_cnt_q == TO_LAST) wd_fire = 1'b1;
            else idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt_q <= 8'd0;
        else        idle_cnt_q <= idle_cnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_fire = 1'b0;
`endif

    // Next-state and output-register logic of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_nc_d   = last_nc_q;
        hdr_valid_d = hdr_valid_q;
        hdr_src_d   = hdr_src_q;
        hdr_dst_d   = hdr_dst_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hdr_err_d   = 1'b0;
        timeout_d   = 1'b0;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = HDR;
                    owner_d     = win_id;
                    grant_d     = id_onehot(win_id);
                    hdr_valid_d = 1'b0;
                    hdr_src_d   = 2'd0;
                    hdr_dst_d   = 2'd0;
                    beat_cnt_d  = 8'd0;
                    if (win_id != CTRL_ID) last_nc_d = win_id;
                end
            end
            HDR: begin
                if (bus_valid) begin
                    hdr_valid_d = 1'b1;
                    hdr_src_d   = bus_data[SRC_LSB +: 2];
                    hdr_dst_d   = bus_data[DST_LSB +: 2];
                    beat_cnt_d  = 8'd1;
                    if (owner_q != CTRL_ID &&
                        bus_data[SRC_LSB +: 2] != owner_q) begin
                        hdr_err_d = 1'b1;
                        rel       = 1'b1;
                    end else if (last[owner_q]) begin
                        rel = 1'b1;
                    end else begin
                        state_d = XFER;
                    end
                end
                if (!req[owner_q]) rel = 1'b1;
                if (wd_fire) begin
                    timeout_d = 1'b1;
                    rel       = 1'b1;
                end
            end
            XFER: begin
                if (bus_valid) begin
                    if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last[owner_q]) rel = 1'b1;
                end
                if (!req[owner_q]) rel = 1'b1;
                if (wd_fire) begin
                    timeout_d = 1'b1;
                    rel       = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 3'd0) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            state_d   = GAP;
            grant_d   = 4'b0000;
            gap_cnt_d = GAP_LAST;
        end
    end

    // State and output registers; reset leaves source 0 next in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            owner_q     <= 2'd0;
            last_nc_q   <= 2'd2;
            hdr_valid_q <= 1'b0;
            hdr_src_q   <= 2'd0;
            hdr_dst_q   <= 2'd0;
            beat_cnt_q  <= 8'd0;
            hdr_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            gap_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_nc_q   <= last_nc_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_src_q   <= hdr_src_d;
            hdr_dst_q   <= hdr_dst_d;
            beat_cnt_q  <= beat_cnt_d;
            hdr_err_q   <= hdr_err_d;
            timeout_q   <= timeout_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = |grant_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_src   = hdr_src_q;
    assign hdr_dst   = hdr_dst_q;
    assign beat_cnt  = beat_cnt_q;
    assign hdr_err   = hdr_err_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 1, meaning the idle cycles forced between a release and the next grant (legal range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the consecutive bus-idle cycles tolerated while granted (legal range 2..255; used only with ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 4 bits: transfer requests indexed by 2-bit source ID; ID 3 is the control module.
REQ-006 The block SHALL have port last, input, 4 bits: the requester's current beat is its final beat.
REQ-007 The block SHALL have port bus_valid, input, 1 bit: the shared bus carries a valid beat (monitored only).
REQ-008 The block SHALL have port bus_data, input, 8 bits: the shared bus data (monitored only).
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot or zero bus ownership.
REQ-010 The block SHALL have port busy, output, 1 bit: a grant is held.
REQ-011 The block SHALL have port hdr_valid, output, 1 bit: the header has been captured for the current grant.
REQ-012 The block SHALL have ports hdr_src and hdr_dst, outputs, 2 bits each: the captured header bus_data[3:2] and bus_data[5:4].
REQ-013 The block SHALL have port beat_cnt, output, 8 bits: beats seen in the current grant, saturating at 255.
REQ-014 The block SHALL have port hdr_err, output, 1 bit: one-cycle pulse on header source mismatch.
REQ-015 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on watchdog release.

Function
REQ-016 The block SHALL implement FSM states IDLE, HDR, XFER and GAP; grant SHALL be nonzero only in HDR and XFER, and busy SHALL equal |grant.
REQ-017 In IDLE with any req bit set, the block SHALL register the winner and assert its grant on the next cycle, then enter HDR.
REQ-018 req[3] SHALL always win; otherwise IDs 0..2 SHALL be picked round-robin starting after the last non-control winner.
REQ-019 In HDR, the first cycle with bus_valid=1 SHALL capture hdr_src/hdr_dst, set hdr_valid, set beat_cnt=1 and enter XFER.
REQ-020 At header capture, if the owner is not 3 and bus_data[3:2] differs from the owner ID, the block SHALL pulse hdr_err, drop grant next cycle and enter GAP.
REQ-021 In XFER, each bus_valid cycle SHALL increment beat_cnt, saturating at 255.
REQ-022 bus_valid=1 with last[owner]=1 in HDR or XFER SHALL drop grant on the next cycle and enter GAP; a single-beat transfer on the header beat is legal.
REQ-023 If req[owner] deasserts in HDR or XFER, the block SHALL drop grant next cycle and enter GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests seen during GAP SHALL wait and not be lost.
REQ-025 hdr_valid, hdr_src, hdr_dst and beat_cnt SHALL hold through GAP and clear on entry to the next HDR.
REQ-026 last and bus_valid from non-owners SHALL be ignored.

Reset
REQ-027 On rst_n=0, the block SHALL immediately, even mid-transfer, set state=IDLE, grant=0, busy=0, hdr_valid=0, hdr_src=0, hdr_dst=0, beat_cnt=0, hdr_err=0, timeout=0, and the round-robin pointer so that ID 0 is next.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, the block SHALL count consecutive bus_valid=0 cycles in HDR/XFER, resetting the count on any beat; on reaching TIMEOUT_CYCLES it SHALL pulse timeout, drop grant next cycle and enter GAP.
REQ-029 Without ARB_TIMEOUT_EN, the block SHALL have no counter and SHALL tie timeout to 0; the port list SHALL be identical in both builds.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the FSM state enum, CTRL_ID=2'b11, and the header field positions SRC_LSB=2 and DST_LSB=4.
REQ-031 The three-way round-robin choice SHALL be sub-module rr_pick3 (inputs req[2:0] and the last winner; output the one-hot pick).

Verification
REQ-032 The bench SHALL check: req=4'b0011 from reset -> grant=0001 first; after release plus GAP -> grant=0010.
REQ-033 The bench SHALL check: req[1] granted, header 8'h24, 3 beats with last on the third -> hdr_src=1, hdr_dst=2, beat_cnt=3, grant=0 on the next cycle.
REQ-034 The bench SHALL check: req=4'b1101 with GAP_CYCLES=2 -> grant=1000; after its release, exactly 2 idle cycles, then grant=0001.
REQ-035 The bench SHALL check: owner 2 sends header 8'h04 -> hdr_err pulse of 1 cycle, grant=0 on the next cycle.
REQ-036 The bench SHALL check: with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, owner 0 stalls after the header -> timeout pulse on the 4th idle cycle and grant drops.
REQ-037 The bench SHALL check: rst_n pulsed low mid-XFER -> all outputs 0 during reset; after release, req[2] alone -> grant=0100.
